hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Parametrised successor to the pipeline hazard unit, for the 5-stage (F/D/E/M/W) RISC-V core.
- Produces operand-forwarding selects, load-use stalls and branch flushes.
- New versus the previous generation:
  - configurable register-file size;
  - multi-cycle load latency, handled by a stall FSM with a down-counter;
  - forwarding can be switched off (stall-only mode);
  - saturating performance counters for stall cycles and flush events.

Parameters:
- NREGS, 32, number of architectural registers; x0 is hardwired zero.
- REG_AW, $clog2(NREGS), register-index width.
- LOAD_LAT, 1, cycles a loaded value is unavailable to a dependent instruction in D; legal range 1..15.
- FWD_EN, 1, 1 = forwarding enabled; 0 = no forwarding, stall on every RAW hazard.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- Rs1D, Rs2D  in  REG_AW  source registers of the instruction in D.
- Rs1E, Rs2E  in  REG_AW  source registers of the instruction in E.
- RdE, RdM, RdW  in  REG_AW  destination registers in E, M and W.
- RegWriteE, RegWriteM, RegWriteW  in  1  register-write enables per stage.
- ResultSrcE  in  2  result-source select in E; 2'b01 means load.
- PCSrcE  in  1  taken branch or jump resolved in E.
- perf_clr  in  1  synchronous clear of both counters.
- ForwardAE, ForwardBE  out  2  operand select: 00 = register file, 01 = W result, 10 = M ALU result.
- StallF, StallD  out  1  hold PC and the IF/ID register.
- FlushD, FlushE  out  1  bubble the IF/ID and ID/EX registers.
- lwStall  out  1  load-use hazard detected or being held.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

Behaviour:
- Reset (reset = 0, asynchronous): FSM goes to IDLE, internal counter = 0, stall_cnt = flush_cnt = 0. All stall/flush outputs = 0; Forward* reflects the current inputs (combinational).
- Match rule: a register matches only when its index is non-zero, equal, and the producing stage's RegWrite is 1. An index of x0 never matches.
- Forwarding with FWD_EN = 1, per operand:
  - M match gives 10; else W match gives 01; else 00.
  - M has priority when both stages match.
  - Purely combinational; zero latency.
- Forwarding with FWD_EN = 0:
  - Forward* is always 00.
  - raw_stall = a D source matches E, M or W; it asserts StallF, StallD and FlushE.
  - Stateless; re-evaluated every cycle.
- Load-use detect: ResultSrcE == 01, RdE ≠ 0, and RdE == Rs1D or RdE == Rs2D.
- FSM states: IDLE, LSTALL.
  - In IDLE, a detect asserts lwStall, StallF, StallD and FlushE in the same cycle.
  - If LOAD_LAT > 1, next state is LSTALL with cnt = LOAD_LAT-1.
  - In LSTALL, outputs are held asserted; cnt decrements each cycle.
  - When cnt == 1, next state is IDLE.
  - Total stall length is exactly LOAD_LAT consecutive cycles.
  - With LOAD_LAT == 1 the FSM never leaves IDLE (classic single-cycle stall).
  - A new detect in the cycle the FSM returns to IDLE starts a fresh sequence.
- Branch flush: PCSrcE asserts FlushD and FlushE in the same cycle.
  - PCSrcE has priority over any stall: StallF and StallD are forced to 0, the FSM is forced to IDLE and cnt is cleared.
  - Rationale: the stalled D instruction is squashed.
- Output equations:
  - FlushE = lwStall | raw_stall | PCSrcE.
  - FlushD = PCSrcE.
  - StallF = StallD = (lwStall | raw_stall) & ~PCSrcE.
- Counters:
  - stall_cnt increments on each cycle with StallD = 1.
  - flush_cnt increments on each cycle with PCSrcE = 1.
  - Both saturate at 2^CNT_W-1.
  - perf_clr takes priority over increment; the next value is 0.
- Reset asserted mid-stall: all outputs drop immediately (asynchronous); the FSM restarts in IDLE.

Decomposition:
- Shared package hazard_pkg:
  - forward-select constants FWD_RF, FWD_W, FWD_M;
  - RESULT_LOAD = 2'b01;
  - FSM state encoding (IDLE, LSTALL).
- Sub-module fwd_sel: per-operand comparator producing the 2-bit select. Instantiated twice (A and B operands).

Test Plan:
- Forwarding priority (FWD_EN = 1): Rs1E = 5, RdM = 5, RegWriteM = 1, RdW = 5, RegWriteW = 1 -> ForwardAE = 10. Drop RegWriteM -> ForwardAE = 01. Rs1E = 0 with matching x0 -> ForwardAE = 00.
- Single-cycle load-use (LOAD_LAT = 1): ResultSrcE = 01, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1 for exactly 1 cycle; stall_cnt = 1.
- Multi-cycle load-use (LOAD_LAT = 3): same stimulus -> stall held exactly 3 cycles, then StallD = 0; stall_cnt = 3.
- Branch during stall: load-use detect with PCSrcE = 1 in the same cycle -> StallF = StallD = 0, FlushD = FlushE = 1, FSM in IDLE next cycle; flush_cnt = 1.
- No-forward mode (FWD_EN = 0): Rs1D = 4, RdM = 4, RegWriteM = 1 -> StallD = 1 and ForwardAE = 00; clears once no stage matches.
- Asynchronous reset and counters:
  - reset low in the 2nd cycle of a LOAD_LAT = 3 stall -> outputs 0 immediately, counters 0.
  - perf_clr with a concurrent stall -> stall_cnt = 0 next cycle.
  - Forced counter at max with CNT_W = 4 -> stays 15.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard unit: forward selects,
// result-source encoding and stall FSM state encoding.
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LSTALL = 1'b1;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding comparator: picks the youngest stage (M before W)
// that writes the register this operand reads.
module fwd_sel
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter bit FWD_EN = 1'b1
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              we_m,
    input  logic              we_w,
    output logic [1:0]        sel
);

    logic hit_m;
    logic hit_w;

    // x0 never matches because it always reads as zero
    assign hit_m = we_m && (rs != '0) && (rs == rd_m);
    assign hit_w = we_w && (rs != '0) && (rs == rd_w);

    always_comb begin
        sel = FWD_RF;
        if (FWD_EN) begin
            if (hit_m) begin
                sel = FWD_M;
            end else if (hit_w) begin
                sel = FWD_W;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage core: forwarding selects, load-use and RAW
// stalls, branch flushes and saturating stall/flush performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NREGS    = 32,
    parameter int REG_AW   = $clog2(NREGS),
    parameter int LOAD_LAT = 1,
    parameter bit FWD_EN   = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic [1:0]        ResultSrcE,
    input  logic              PCSrcE,
    input  logic              perf_clr,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              FlushD,
    output logic              FlushE,
    output logic              lwStall,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

    logic [0:0] state;
    logic [0:0] state_nx;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;
    logic       load_use;
    logic       raw_stall;
    logic       stall_any;

    function automatic logic hit(input logic [REG_AW-1:0] rs,
                                 input logic [REG_AW-1:0] rd,
                                 input logic              we);
        return we && (rs != '0) && (rs == rd);
    endfunction

    fwd_sel #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_a (
        .rs(Rs1E), .rd_m(RdM), .rd_w(RdW),
        .we_m(RegWriteM), .we_w(RegWriteW), .sel(ForwardAE)
    );

    fwd_sel #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_b (
        .rs(Rs2E), .rd_m(RdM), .rd_w(RdW),
        .we_m(RegWriteM), .we_w(RegWriteW), .sel(ForwardBE)
    );

    assign load_use = (ResultSrcE == RESULT_LOAD) && (RdE != '0)
                      && ((RdE == Rs1D) || (RdE == Rs2D));

    // Without forwarding every in-flight writer of a D source must drain first
    always_comb begin
        raw_stall = 1'b0;
        if (!FWD_EN) begin
            raw_stall = reset &&
                        (hit(Rs1D, RdE, RegWriteE) || hit(Rs1D, RdM, RegWriteM) ||
                         hit(Rs1D, RdW, RegWriteW) || hit(Rs2D, RdE, RegWriteE) ||
                         hit(Rs2D, RdM, RegWriteM) || hit(Rs2D, RdW, RegWriteW));
        end
    end

    assign lwStall   = reset && ((state == LSTALL) || load_use);
    assign stall_any = lwStall || raw_stall;
    assign StallF    = reset && stall_any && !PCSrcE;
    assign StallD    = reset && stall_any && !PCSrcE;
    assign FlushD    = reset && PCSrcE;
    assign FlushE    = reset && (stall_any || PCSrcE);

    // A taken branch squashes the stalled D instruction, so it cancels the hold
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (PCSrcE) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else if (state == LSTALL) begin
            if (cnt == 4'd1) begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end else begin
                cnt_nx = cnt - 4'd1;
            end
        end else if (load_use && (LOAD_LAT > 1)) begin
            state_nx = LSTALL;
            cnt_nx   = LAT_M1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (perf_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (StallD && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (PCSrcE && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: four configurations share one stimulus
// stream and are compared every cycle against a behavioural model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteE, RegWriteM, RegWriteW;
    logic [1:0] ResultSrcE;
    logic       PCSrcE, perf_clr;

    logic [1:0]  fa [4];
    logic [1:0]  fb [4];
    logic        sf [4];
    logic        sd [4];
    logic        fd [4];
    logic        fe [4];
    logic        lw [4];
    logic [31:0] sc [4];
    logic [31:0] fc [4];
    logic [3:0]  sc4, fc4;

    int     errors = 0;
    int     checks = 0;

    int     lat_of [4] = '{1, 3, 2, 3};
    bit     fwd_of [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    longint cmax   [4] = '{64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'd15};

    int     hold  [4];
    longint mscnt [4];
    longint mfcnt [4];

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_LAT(1), .FWD_EN(1'b1), .CNT_W(32)) dut0 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .perf_clr(perf_clr),
        .ForwardAE(fa[0]), .ForwardBE(fb[0]), .StallF(sf[0]), .StallD(sd[0]), .FlushD(fd[0]),
        .FlushE(fe[0]), .lwStall(lw[0]), .stall_cnt(sc[0]), .flush_cnt(fc[0]));

    hazard_ctrl #(.LOAD_LAT(3), .FWD_EN(1'b1), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .perf_clr(perf_clr),
        .ForwardAE(fa[1]), .ForwardBE(fb[1]), .StallF(sf[1]), .StallD(sd[1]), .FlushD(fd[1]),
        .FlushE(fe[1]), .lwStall(lw[1]), .stall_cnt(sc[1]), .flush_cnt(fc[1]));

    hazard_ctrl #(.LOAD_LAT(2), .FWD_EN(1'b0), .CNT_W(32)) dut2 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .perf_clr(perf_clr),
        .ForwardAE(fa[2]), .ForwardBE(fb[2]), .StallF(sf[2]), .StallD(sd[2]), .FlushD(fd[2]),
        .FlushE(fe[2]), .lwStall(lw[2]), .stall_cnt(sc[2]), .flush_cnt(fc[2]));

    hazard_ctrl #(.LOAD_LAT(3), .FWD_EN(1'b1), .CNT_W(4)) dut3 (
        .clk(clk), .reset(reset), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW), .RegWriteE(RegWriteE), .RegWriteM(RegWriteM),
        .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE), .perf_clr(perf_clr),
        .ForwardAE(fa[3]), .ForwardBE(fb[3]), .StallF(sf[3]), .StallD(sd[3]), .FlushD(fd[3]),
        .FlushE(fe[3]), .lwStall(lw[3]), .stall_cnt(sc4), .flush_cnt(fc4));

    assign sc[3] = {28'd0, sc4};
    assign fc[3] = {28'd0, fc4};

    // Behavioural rules: a register matches only when written, non-zero and equal
    function automatic bit hitReg(input logic [4:0] rs, input logic [4:0] rd, input logic we);
        return we && (rd != 5'd0) && (rs == rd);
    endfunction

    function automatic bit srcHit(input logic [4:0] rs);
        return hitReg(rs, RdE, RegWriteE) || hitReg(rs, RdM, RegWriteM) || hitReg(rs, RdW, RegWriteW);
    endfunction

    function automatic bit loadUse();
        return (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    endfunction

    function automatic bit expRaw(input int i);
        if (fwd_of[i]) return 1'b0;
        return reset && (srcHit(Rs1D) || srcHit(Rs2D));
    endfunction

    function automatic bit expLw(input int i);
        return reset && ((hold[i] > 0) || loadUse());
    endfunction

    function automatic bit expStall(input int i);
        return (expLw(i) || expRaw(i)) && !PCSrcE;
    endfunction

    function automatic bit expFlushE(input int i);
        return reset && (expLw(i) || expRaw(i) || PCSrcE);
    endfunction

    function automatic logic [1:0] expFwd(input int i, input logic [4:0] rs);
        if (!fwd_of[i]) return 2'b00;
        if (hitReg(rs, RdM, RegWriteM)) return 2'b10;
        if (hitReg(rs, RdW, RegWriteW)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic checkOutput(input string name, input int idx, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s[dut%0d] at %0t: got %0d, expected %0d", name, idx, $time, act, exp);
        end
    endtask

    // Model state: remaining forced-stall cycles plus saturating counters
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                hold[i]  <= 0;
                mscnt[i] <= 0;
                mfcnt[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (perf_clr) begin
                    mscnt[i] <= 0;
                    mfcnt[i] <= 0;
                end else begin
                    if (expStall(i) && mscnt[i] < cmax[i]) mscnt[i] <= mscnt[i] + 1;
                    if (PCSrcE && mfcnt[i] < cmax[i]) mfcnt[i] <= mfcnt[i] + 1;
                end
                if (PCSrcE) hold[i] <= 0;
                else if (hold[i] > 0) hold[i] <= hold[i] - 1;
                else if (loadUse()) hold[i] <= lat_of[i] - 1;
            end
        end
    end

    // Every falling edge compares all four instances against the model
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            checkOutput("ForwardAE", i, fa[i], expFwd(i, Rs1E));
            checkOutput("ForwardBE", i, fb[i], expFwd(i, Rs2E));
            checkOutput("StallF", i, sf[i], expStall(i));
            checkOutput("StallD", i, sd[i], expStall(i));
            checkOutput("FlushD", i, fd[i], reset && PCSrcE);
            checkOutput("FlushE", i, fe[i], expFlushE(i));
            checkOutput("lwStall", i, lw[i], expLw(i));
            checkOutput("stall_cnt", i, sc[i], mscnt[i]);
            checkOutput("flush_cnt", i, fc[i], mfcnt[i]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0;
        PCSrcE = 0; perf_clr = 0;
    endtask

    task automatic setLoadUse();
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
    endtask

    task automatic applyStimulus();
        Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
        Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
        RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
        RdW  = 5'($urandom_range(0, 3));
        RegWriteE = 1'($urandom_range(0, 1));
        RegWriteM = 1'($urandom_range(0, 1));
        RegWriteW = 1'($urandom_range(0, 1));
        ResultSrcE = 2'($urandom_range(0, 3));
        PCSrcE   = ($urandom_range(0, 7) == 0);
        perf_clr = ($urandom_range(0, 31) == 0);
        reset    = !($urandom_range(0, 63) == 0);
    endtask

    initial begin
        idle();
        setLoadUse();
        #1 reset = 1'b0;
        #1;
        checkOutput("lit_reset_StallD", 1, sd[1], 0);
        checkOutput("lit_reset_lwStall", 1, lw[1], 0);
        checkOutput("lit_reset_FlushE", 1, fe[1], 0);
        checkOutput("lit_reset_stall_cnt", 1, sc[1], 0);
        idle();
        tick();
        tick();
        reset = 1'b1;

        Rs1E = 5; RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1;
        #1 checkOutput("lit_fwd_M_priority", 0, fa[0], 2);
        checkOutput("lit_fwd_disabled", 2, fa[2], 0);
        RegWriteM = 0;
        #1 checkOutput("lit_fwd_W", 0, fa[0], 1);
        Rs1E = 0; RdM = 0; RdW = 0; RegWriteM = 1;
        #1 checkOutput("lit_fwd_x0", 0, fa[0], 0);
        idle();

        tick();
        setLoadUse();
        #1 checkOutput("lit_lu1_StallD", 0, sd[0], 1);
        checkOutput("lit_lu1_StallF", 0, sf[0], 1);
        checkOutput("lit_lu1_FlushE", 0, fe[0], 1);
        tick();
        idle();
        #1 checkOutput("lit_lu1_release", 0, sd[0], 0);
        checkOutput("lit_lu1_stall_cnt", 0, sc[0], 1);
        checkOutput("lit_lu3_hold1", 1, sd[1], 1);
        tick();
        checkOutput("lit_lu3_hold2", 1, sd[1], 1);
        tick();
        checkOutput("lit_lu3_release", 1, sd[1], 0);
        checkOutput("lit_lu3_stall_cnt", 1, sc[1], 3);

        tick();
        setLoadUse();
        PCSrcE = 1;
        #1 checkOutput("lit_br_StallD", 1, sd[1], 0);
        checkOutput("lit_br_StallF", 1, sf[1], 0);
        checkOutput("lit_br_FlushD", 1, fd[1], 1);
        checkOutput("lit_br_FlushE", 1, fe[1], 1);
        tick();
        idle();
        #1 checkOutput("lit_br_idle", 1, lw[1], 0);
        checkOutput("lit_br_flush_cnt", 1, fc[1], 1);

        tick();
        Rs1D = 4; RdM = 4; RegWriteM = 1;
        #1 checkOutput("lit_nofwd_stall", 2, sd[2], 1);
        checkOutput("lit_nofwd_fwd", 2, fa[2], 0);
        checkOutput("lit_fwd_nostall", 0, sd[0], 0);
        tick();
        RegWriteM = 0;
        #1 checkOutput("lit_nofwd_clear", 2, sd[2], 0);

        tick();
        idle();
        setLoadUse();
        tick();
        idle();
        #1 checkOutput("lit_rst_midstall_pre", 1, sd[1], 1);
        reset = 1'b0;
        #1 checkOutput("lit_rst_midstall_StallD", 1, sd[1], 0);
        checkOutput("lit_rst_midstall_FlushE", 1, fe[1], 0);
        checkOutput("lit_rst_midstall_cnt", 1, sc[1], 0);
        tick();
        reset = 1'b1;
        #1 checkOutput("lit_rst_idle", 1, lw[1], 0);

        tick();
        setLoadUse();
        perf_clr = 1;
        #1 checkOutput("lit_clr_stalling", 0, sd[0], 1);
        tick();
        idle();
        #1 checkOutput("lit_clr_stall_cnt", 0, sc[0], 0);

        setLoadUse();
        repeat (20) tick();
        checkOutput("lit_sat_stall_cnt", 3, sc[3], 15);
        idle();
        PCSrcE = 1;
        repeat (20) tick();
        checkOutput("lit_sat_flush_cnt", 3, fc[3], 15);
        idle();

        for (int n = 0; n < 3000; n++) begin
            tick();
            applyStimulus();
        end
        tick();
        reset = 1'b1;
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
